demux_1to4_stream: RTL and testbench
====================================

// Module: demux_1to4_stream
// PURPOSE
//  Registered 1-to-4 stream distributor with valid/ready handshake on every side.
//  Routes each input beat to one of four output channels, chosen by a per-beat select or by an internal round-robin pointer.
//  Each channel has a one-entry output register.
//  Sits downstream of the source stage; it is the clocked successor of the combinational 1-to-4 demux used for select decoding.
// PARAMETERS
//  DATA_W   8   width of data payload per beat
//  CNT_W   16   width of accepted-beat counter (saturating)
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid & in_ready
//  in_data    in   DATA_W     input payload
//  in_sel     in   2          destination channel (used when mode=0)
//  mode       in   1          0 = addressed (in_sel), 1 = round-robin (rr_ptr)
//  out_valid  out  4          per-channel valid, bit k = channel k
//  out_ready  in   4          per-channel ready, bit k = channel k
//  out_data   out  4*DATA_W   channel k payload at [k*DATA_W +: DATA_W]
//  rr_ptr     out  2          current round-robin target
//  beat_cnt   out  CNT_W      total accepted input beats, saturates at all-ones
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, out_data=0, rr_ptr=0, beat_cnt=0 immediately.
//   - in_ready=0 while in reset.
//  Target channel:
//   - tgt = mode ? rr_ptr : in_sel. Combinational, sampled in the same cycle as the handshake.
//  Readiness:
//   - in_ready = ~out_valid[tgt] | out_ready[tgt].
//   - Combinational path from out_ready and mode/in_sel to in_ready is intentional.
//  Accept (in_valid & in_ready):
//   - On the next edge, out_data[tgt] <= in_data and out_valid[tgt] <= 1.
//   - Latency: input beat to out_valid is exactly 1 cycle.
//  Drain:
//   - out_valid[k] & out_ready[k] with no load to k: out_valid[k] <= 0 next edge.
//   - out_data[k] holds its last value.
//  Simultaneous load and drain on the same channel:
//   - out_valid stays 1 and out_data takes the new beat.
//   - This gives full throughput of 1 beat/cycle per channel.
//  Independence:
//   - Channels drain independently; a stalled channel blocks only beats targeting it.
//   - No head-of-line reordering across accepted beats.
//  Stability:
//   - out_valid[k]=1 with out_ready[k]=0 holds out_data[k] stable until accepted.
//   - in_valid may be withdrawn without acceptance; no state change results.
//  Round-robin pointer:
//   - rr_ptr advances 3->0 wrap, +1 mod 4, only on an accepted beat with mode=1.
//   - It does not move in mode=0 or on stalls.
//  Mode switches:
//   - A mode change takes effect in the same cycle (tgt is combinational).
//   - rr_ptr is retained across mode switches, never reset by them.
//   - Pending channel contents are unaffected.
//  beat_cnt: +1 per accepted beat; at 2^CNT_W-1 it holds.
//  Reset mid-operation: pending beats are discarded; no output beat appears after rst_n rises until a new accept.
//  No state machine beyond the per-channel valid bits and rr_ptr; no X on any output after reset.
// TESTING
//  1. Addressed mode, all out_ready=1, send 0xA0..0xA3 with in_sel=0..3 back-to-back
//     -> out_valid one-hot 0001,0010,0100,1000 each 1 cycle later; in_ready=1 throughout; beat_cnt=4.
//  2. Round-robin mode, out_ready=4'b1111, 8 beats 0x10..0x17
//     -> ch0 gets 0x10,0x14; ch1 gets 0x11,0x15; ...; rr_ptr wraps to 0 after 4 beats and ends at 0.
//  3. Backpressure: mode=0, out_ready[2]=0, send 0x55 to ch2, then 0x66 to ch2, then 0x77 to ch1
//     -> 0x55 held on ch2; in_ready=0 for 0x66; switching in_sel to 1 accepts 0x77 on ch1 next cycle.
//  4. Same-channel load+drain: ch3 full, out_ready[3]=1, new beat 0x9C to ch3
//     -> out_valid[3] stays 1; out_data ch3 = 0x9C next cycle; no bubble.
//  5. Mode switch with rr_ptr=2: accept 2 beats in mode=0, return to mode=1
//     -> next RR beat goes to ch2, rr_ptr becomes 3.
//  6. Async reset asserted mid-burst with channels 0 and 1 valid
//     -> out_valid=0, rr_ptr=0, beat_cnt=0 without a clock edge; after release, no output until a new accept.
//     Also preload beat_cnt near max (CNT_W=4): 17 beats -> beat_cnt=15.

Source files
------------

// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream distributor: each input beat lands in a one-entry
// output register for the channel picked by in_sel or by a round-robin pointer.
module demux_1to4_stream #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   input  logic [1:0]            in_sel,
   input  logic                  mode,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic [4*DATA_W-1:0]   out_data,
   output logic [1:0]            rr_ptr,
   output logic [CNT_W-1:0]      beat_cnt
);

   logic [3:0]          valid_q, valid_d;
   logic [4*DATA_W-1:0] data_q, data_d;
   logic [1:0]          rr_q, rr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          tgt;
   logic                accept;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   always_comb begin
      tgt      = mode ? rr_q : in_sel;
      // A full channel can still take a beat when it drains in the same cycle.
      in_ready = rst_n & (~valid_q[tgt] | out_ready[tgt]);
      accept   = in_valid & in_ready;

      valid_d = valid_q & ~out_ready;
      data_d  = data_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;

      if (accept) begin
         for (int k = 0; k < 4; k++) begin
            if (tgt == 2'(k)) begin
               valid_d[k]                    = 1'b1;
               data_d[k*DATA_W +: DATA_W]    = in_data;
            end
         end
         cnt_d = sat_inc(cnt_q);
         if (mode) rr_d = rr_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign rr_ptr    = rr_q;
   assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Scoreboard bench for demux_1to4_stream: per-channel expected-data queues
// filled on accepted beats and drained on output handshakes.
module tb_demux_1to4_stream;

   localparam int DW = 8;
   localparam int CW = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic [1:0]      in_sel;
   logic            mode;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic [4*DW-1:0] out_data;
   logic [1:0]      rr_ptr;
   logic [CW-1:0]   beat_cnt;

   demux_1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .mode(mode), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .rr_ptr(rr_ptr), .beat_cnt(beat_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [DW-1:0] exp_q [4][$];
   logic [3:0]    m_vld;
   logic [1:0]    m_rr;
   logic [CW-1:0] m_cnt;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_vld = '0;
      m_rr  = '0;
      m_cnt = '0;
      for (int k = 0; k < 4; k++) exp_q[k].delete();
   endtask

   // One clock cycle with the currently driven inputs; checks both sides.
   task automatic cyc();
      logic [1:0] t;
      logic       rdy;
      logic       acc;
      #1;
      t   = mode ? m_rr : in_sel;
      rdy = !m_vld[t] || out_ready[t];
      chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
      for (int k = 0; k < 4; k++) begin
         if (out_valid[k]) begin
            if (exp_q[k].size() == 0) chk("spurious_beat", 64'd1, 64'd0);
            else chk("out_data", {56'd0, out_data[k*DW +: DW]}, {56'd0, exp_q[k][0]});
         end
      end
      for (int k = 0; k < 4; k++)
         if (out_valid[k] && out_ready[k] && exp_q[k].size() > 0) void'(exp_q[k].pop_front());
      acc   = in_valid && rdy;
      m_vld = m_vld & ~out_ready;
      if (acc) begin
         exp_q[t].push_back(in_data);
         m_vld[t] = 1'b1;
         m_cnt    = (m_cnt == {CW{1'b1}}) ? m_cnt : m_cnt + 1'b1;
         if (mode) m_rr = m_rr + 2'd1;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {60'd0, out_valid}, {60'd0, m_vld});
      chk("rr_ptr", {62'd0, rr_ptr}, {62'd0, m_rr});
      chk("beat_cnt", {60'd0, beat_cnt}, {60'd0, m_cnt});
   endtask

   task automatic send(input logic md, input logic [1:0] sel, input logic [DW-1:0] d);
      in_valid = 1'b1;
      mode     = md;
      in_sel   = sel;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; mode = 1'b0; out_ready = '0;
      model_reset();
      #12;
      chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
      chk("rst_out_data", {32'd0, out_data}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_beat_cnt", {60'd0, beat_cnt}, 64'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Addressed mode, all ready, back-to-back to each channel
      out_ready = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         send(1'b0, 2'(i), 8'hA0 + 8'(i));
         chk("t1_onehot", {60'd0, out_valid}, 64'd1 << i);
      end
      chk("t1_cnt", {60'd0, beat_cnt}, 64'd4);
      idle(1);

      // Round-robin mode, 8 beats
      for (int i = 0; i < 8; i++) send(1'b1, 2'd0, 8'h10 + 8'(i));
      chk("t2_rr_end", {62'd0, rr_ptr}, 64'd0);
      idle(1);

      // Backpressure on ch2; stalled beat withdrawn, ch1 proceeds
      out_ready = 4'b1011;
      send(1'b0, 2'd2, 8'h55);
      send(1'b0, 2'd2, 8'h66);
      chk("t3_stall_ready", {63'd0, in_ready}, 64'd0);
      send(1'b0, 2'd1, 8'h77);
      chk("t3_ch1", {56'd0, out_data[1*DW +: DW]}, 64'h77);
      chk("t3_ch2_hold", {56'd0, out_data[2*DW +: DW]}, 64'h55);
      idle(2);
      out_ready = 4'b1111;
      idle(1);

      // Same-channel load and drain on ch3
      out_ready = 4'b0111;
      send(1'b0, 2'd3, 8'h3C);
      idle(1);
      out_ready = 4'b1111;
      send(1'b0, 2'd3, 8'h9C);
      chk("t4_vld3", {63'd0, out_valid[3]}, 64'd1);
      chk("t4_data3", {56'd0, out_data[3*DW +: DW]}, 64'h9C);
      idle(1);

      // Mode switch retains rr_ptr
      send(1'b1, 2'd0, 8'h21);
      send(1'b1, 2'd0, 8'h22);
      send(1'b0, 2'd0, 8'h23);
      send(1'b0, 2'd1, 8'h24);
      send(1'b1, 2'd0, 8'h25);
      chk("t5_ch2", {56'd0, out_data[2*DW +: DW]}, 64'h25);
      chk("t5_rr", {62'd0, rr_ptr}, 64'd3);
      idle(2);

      // Async reset mid-burst with ch0/ch1 pending
      out_ready = 4'b1100;
      send(1'b0, 2'd0, 8'hC0);
      send(1'b0, 2'd1, 8'hC1);
      in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hC2;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_vld", {60'd0, out_valid}, 64'd0);
      chk("t6_rr", {62'd0, rr_ptr}, 64'd0);
      chk("t6_cnt", {60'd0, beat_cnt}, 64'd0);
      chk("t6_in_ready", {63'd0, in_ready}, 64'd0);
      model_reset();
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 4'b1111;
      idle(2);
      chk("t6_no_out", {60'd0, out_valid}, 64'd0);

      // Counter saturation
      for (int i = 0; i < 17; i++) send(1'b1, 2'd0, 8'(i));
      chk("t6_sat", {60'd0, beat_cnt}, 64'd15);
      idle(3);
      for (int k = 0; k < 4; k++) chk("drain_empty", 64'(exp_q[k].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
